wb_arbiter: RTL and testbench

//  Writeback-side driver of the 32x64 register file write port (WriteData/RD/RegWrite).

---
 rtl/wb_arbiter.sv | 113 +++++++++++
 tb/tb_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and FIFO-buffered load results into the register-file write port
// Ports: clk, reset (async, active-low); ALU result in (alu_valid/alu_rd/alu_data, alu_ready);
// load result in (mem_valid/mem_rd/mem_data, mem_ready); load issue (issue_valid/issue_rd);
// busy scoreboard out; registered write port (RegWrite/RD/WriteData); fifo_count.
// Optional WB_BYPASS_EN adds rs1/rs2 lookups with fwd1/fwd2 hit and data from the write port.
module wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [ADDR_W-1:0]             mem_rd,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          mem_ready,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_rd,
    output logic [31:0]                   busy,
    output logic                          RegWrite,
    output logic [ADDR_W-1:0]             RD,
    output logic [DATA_W-1:0]             WriteData,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0]             rs1,
    input  logic [ADDR_W-1:0]             rs2,
    output logic                          fwd1_hit,
    output logic                          fwd2_hit,
    output logic [DATA_W-1:0]             fwd1_data,
    output logic [DATA_W-1:0]             fwd2_data,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] q_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [SW-1:0]     starve, starve_nxt;
    logic              empty, full, force_ld, pop, take_alu, push;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       busy_nxt;

    always_comb begin
        empty    = fifo_count == '0;
        full     = fifo_count == CW'(FIFO_DEPTH);
        force_ld = !empty && starve == SW'(STARVE_MAX);
        pop      = !empty && (force_ld || !alu_valid);
        take_alu = alu_valid && !force_ld;
        push     = mem_valid && !full;
        sel_rd   = pop ? q_rd[rptr] : alu_rd;
        sel_data = pop ? q_data[rptr] : alu_data;
        // once the FIFO is non-empty and not popped, the ALU must have won
        starve_nxt = (pop || empty) ? '0 :
                     (take_alu && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
        // clear first so a same-cycle issue to the same register wins
        busy_nxt = busy;
        if (pop)
            busy_nxt[q_rd[rptr]] = 1'b0;
        if (issue_valid)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign alu_ready = !force_ld;
    assign mem_ready = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= mem_rd;
            q_data[wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            starve     <= '0;
            busy       <= '0;
            RegWrite   <= 1'b0;
            RD         <= '0;
            WriteData  <= '0;
        end else begin
            wptr       <= wptr + PW'(push);
            rptr       <= rptr + PW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            starve     <= starve_nxt;
            busy       <= busy_nxt;
            RegWrite   <= (pop || take_alu) && sel_rd != '0;
            if (pop || take_alu) begin
                RD        <= sel_rd;
                WriteData <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // covers the cycle before the register-file array holds the value
    assign fwd1_hit  = RegWrite && RD != '0 && RD == rs1;
    assign fwd2_hit  = RegWrite && RD != '0 && RD == rs2;
    assign fwd1_data = WriteData;
    assign fwd2_data = WriteData;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus against a queue-based model of wb_arbiter
module tb_wb_arbiter;
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic [2:0]  fifo_count;

    int n_chk = 0;
    int n_fail = 0;

    ent_t        q[$];
    int          starve;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_wd;

    wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0;
        m_busy = '0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_wd   = '0;
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [63:0] md,
                         input logic iv, input logic [4:0] ir);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        issue_valid = iv; issue_rd = ir;
    endtask

    task automatic step();
        bit   nonempty, frc, popped, can_push;
        ent_t e;
        #1;
        nonempty = q.size() > 0;
        frc      = nonempty && starve == 3;
        check("alu_ready", alu_ready, !frc);
        check("mem_ready", mem_ready, q.size() < 4);
        check("fifo_count", fifo_count, q.size());
        check("busy", busy, m_busy);
        check("RegWrite", RegWrite, m_we);
        if (m_we) begin
            check("RD", RD, m_rd);
            check("WriteData", WriteData, m_wd);
        end
        can_push = mem_valid && q.size() < 4;
        popped = 0;
        if (frc || (nonempty && !alu_valid)) begin
            e = q.pop_front();
            popped = 1;
            m_we = e.rd != 0; m_rd = e.rd; m_wd = e.data;
            if (e.rd != 0) m_busy[e.rd] = 1'b0;
        end else if (alu_valid) begin
            m_we = alu_rd != 0; m_rd = alu_rd; m_wd = alu_data;
        end else begin
            m_we = 1'b0;
        end
        if (popped || !nonempty) starve = 0;
        else if (starve < 3) starve++;
        if (can_push) q.push_back('{mem_rd, mem_data});
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b0;
        #1;
        check({tag, "_we"}, RegWrite, 0);
        check({tag, "_rd"}, RD, 0);
        check({tag, "_wd"}, WriteData, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cnt"}, fifo_count, 0);
        check({tag, "_mem_ready"}, mem_ready, 1);
        check({tag, "_alu_ready"}, alu_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("por_we", RegWrite, 0);
        check("por_cnt", fifo_count, 0);
        check("por_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // three loads queued behind the ALU, busy = regs 2 and 5, then async reset
        drive(1, 1, 64'h11, 1, 10, 64'hA0, 1, 2); step();
        drive(1, 1, 64'h12, 1, 11, 64'hA1, 1, 5); step();
        drive(1, 1, 64'h13, 1, 12, 64'hA2, 0, 0); step();
        #1;
        check("mid_cnt", fifo_count, 3);
        check("mid_busy", busy, 32'h0000_0024);
        async_reset("rst");

        // ALU only
        drive(1, 5, 64'hDEAD, 0, 0, 0, 0, 0); step();
        check("alu_we", RegWrite, 1);
        check("alu_rd", RD, 5);
        check("alu_wd", WriteData, 64'hDEAD);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // load + scoreboard
        drive(0, 0, 0, 0, 0, 0, 1, 7); step();
        check("ld_busy7_set", busy[7], 1);
        drive(0, 0, 0, 1, 7, 64'h77, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        check("ld_we", RegWrite, 1);
        check("ld_rd", RD, 7);
        check("ld_busy7_clr", busy[7], 0);

        // starvation: one load behind a continuous ALU stream
        drive(1, 3, 64'h300, 1, 4, 64'h400, 0, 0); step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 3, 64'h301 + i, 0, 0, 0, 0, 0); step();
        end

        // full FIFO with ALU held high, then drain
        for (int i = 0; i < 6; i++) begin
            drive(1, 6, 64'h600 + i, 1, 5'(16 + i), 64'hF00 + i, 0, 0); step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        end

        // x0 load and same-cycle set/clear
        drive(0, 0, 0, 0, 0, 0, 1, 9); step();
        drive(0, 0, 0, 1, 0, 64'hBAD, 0, 0); step();
        drive(0, 0, 0, 1, 9, 64'h99, 0, 0); step();
        check("x0_we", RegWrite, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 9); step();
        check("x9_we", RegWrite, 1);
        check("set_wins", busy[9], 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 2) == 0, 5'($urandom), {$urandom, $urandom},
                  ($urandom % 5) < 2, 5'($urandom), {$urandom, $urandom},
                  ($urandom % 10) < 3, 5'($urandom));
            step();
            if (i == 1500) async_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
